// File: rtl/fme_ip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fme_ip_ctrl
//  Description : Sequencer for one 8x8 fractional-pel interpolation pass of
//                the FME datapath (separable 8-tap horizontal, then vertical
//                filter). It issues reference-row reads, selects the filter
//                type for each direction, drives the pipeline enables and
//                vertical window shifts, and flags valid output rows.
//
//  Ports
//    clk, rst          : clock, asynchronous active-high reset
//    start_i           : start one pass (accepted only when idle)
//    frac_x_i/frac_y_i : fractional MV (0 int, 1 qtr, 2 half, 3 three-qtr)
//    base_addr_i       : reference buffer address of reference row 0
//    out_ready_i       : downstream accepts the current output row
//    busy_o, done_o    : pass in progress / one-cycle completion pulse
//    ref_rd_en_o/_addr_o : reference buffer read request
//    pipe_en_o         : global datapath enable (low while stalled)
//    hor_en_o, hor_type_o, hor_bypass_o : horizontal filter control
//    win_shift_o, ver_type_o, ver_bypass_o : vertical window/filter control
//    out_valid_o, out_row_o, out_last_o : output row handshake
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fme_ip_ctrl #(
    parameter int ADDR_W     = 7,
    parameter int ROW_STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        frac_x_i,
    input  logic [1:0]        frac_y_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ref_rd_en_o,
    output logic [ADDR_W-1:0] ref_rd_addr_o,
    output logic              pipe_en_o,
    output logic              hor_en_o,
    output logic [1:0]        hor_type_o,
    output logic              hor_bypass_o,
    output logic              win_shift_o,
    output logic [1:0]        ver_type_o,
    output logic              ver_bypass_o,
    output logic              out_valid_o,
    output logic [2:0]        out_row_o,
    output logic              out_last_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_stride       = ADDR_W'(ROW_STRIDE);
    localparam logic [3:0]        c_last_rd_byp  = 4'd7;   // 8 rows
    localparam logic [3:0]        c_last_rd_full = 4'd14;  // 15 rows (8 + 7 taps)
    localparam logic [3:0]        c_first_out    = 4'd7;   // vertical taps fill

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_hor_type;
    logic [1:0]        r_ver_type;
    logic              r_hor_bypass;
    logic              r_ver_bypass;
    logic [ADDR_W-1:0] r_base;
    logic [3:0]        r_rd_cnt;
    logic [3:0]        r_sh_cnt;
    logic              r_hor_en;
    logic              r_win_shift;
    logic              r_done;

    logic              w_accept;
    logic              w_stall;
    logic              w_adv;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_out_valid;
    logic [2:0]        w_out_row;
    logic              w_out_last;
    logic [3:0]        w_last_rd;
    logic [ADDR_W-1:0] w_first_row;
    logic [ADDR_W-1:0] w_row_idx;
    logic [ADDR_W-1:0] w_rd_addr;

    // Filter type coding: half -> 0, quarter -> 1, three-quarter -> 2.
    // Integer position uses the bypass flag with type 0.
    function automatic logic [1:0] frac_to_type(input logic [1:0] frac);
        logic [1:0] t;
        case (frac)
            2'd1:    t = 2'd1;
            2'd3:    t = 2'd2;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Output row generation and stall
    // ------------------------------------------------------------------
    // Without vertical filtering every shifted row is an output row; with
    // the 8-tap vertical filter the first 7 shifts only prime the window.
    always_comb begin
        w_out_valid = r_win_shift & (r_ver_bypass | (r_sh_cnt >= c_first_out));
        w_out_row   = 3'd0;
        if (w_out_valid) begin
            w_out_row = r_ver_bypass ? r_sh_cnt[2:0] : 3'(r_sh_cnt - c_first_out);
        end
        w_out_last  = w_out_valid & (w_out_row == 3'd7);
    end

    assign w_stall = w_out_valid & ~out_ready_i;
    assign w_adv   = ~w_stall;

    // ------------------------------------------------------------------
    // Read address: base + (first_row + r) * stride, modulo 2^ADDR_W.
    // Vertical bypass skips the 3 rows of upper filter support.
    // ------------------------------------------------------------------
    assign w_last_rd   = r_ver_bypass ? c_last_rd_byp : c_last_rd_full;
    assign w_first_row = r_ver_bypass ? ADDR_W'(3) : '0;
    assign w_row_idx   = ADDR_W'(r_rd_cnt) + w_first_row;
    assign w_rd_addr   = r_base + (w_row_idx * c_stride);

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_READ;
                    w_accept    = 1'b1;
                end
            end
            S_READ: begin
                w_busy  = 1'b1;
                w_rd_en = w_adv;
                if (r_rd_cnt == w_last_rd) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_out_last & out_ready_i) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, latched pass parameters and delay chain.
    // Everything freezes while the output row is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hor_type   <= 2'd0;
            r_ver_type   <= 2'd0;
            r_hor_bypass <= 1'b0;
            r_ver_bypass <= 1'b0;
            r_base       <= '0;
            r_rd_cnt     <= 4'd0;
            r_sh_cnt     <= 4'd0;
            r_hor_en     <= 1'b0;
            r_win_shift  <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_adv) begin
            r_state     <= w_state_nxt;
            r_done      <= (r_state == S_DONE);
            // read data reaches the horizontal filter one cycle after the
            // read, and the filtered row enters the window one cycle later
            r_hor_en    <= w_rd_en;
            r_win_shift <= r_hor_en;
            if (w_accept) begin
                r_hor_type   <= frac_to_type(frac_x_i);
                r_ver_type   <= frac_to_type(frac_y_i);
                r_hor_bypass <= (frac_x_i == 2'd0);
                r_ver_bypass <= (frac_y_i == 2'd0);
                r_base       <= base_addr_i;
                r_rd_cnt     <= 4'd0;
                r_sh_cnt     <= 4'd0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + 4'd1;
                end
                if (r_win_shift) begin
                    r_sh_cnt <= r_sh_cnt + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o        = w_busy;
    assign done_o        = r_done;
    assign ref_rd_en_o   = w_rd_en;
    assign ref_rd_addr_o = w_rd_en ? w_rd_addr : '0;
    assign pipe_en_o     = w_adv;
    assign hor_en_o      = r_hor_en;
    assign hor_type_o    = r_hor_type;
    assign hor_bypass_o  = r_hor_bypass;
    assign win_shift_o   = r_win_shift;
    assign ver_type_o    = r_ver_type;
    assign ver_bypass_o  = r_ver_bypass;
    assign out_valid_o   = w_out_valid;
    assign out_row_o     = w_out_row;
    assign out_last_o    = w_out_last;

endmodule
`default_nettype wire

// File: tb/tb_fme_ip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fme_ip_ctrl
//  Description : Self-checking bench for fme_ip_ctrl. Two instances share
//                all inputs (ROW_STRIDE 1 and 16). Expected behaviour comes
//                from a timeline model counting unstalled cycles since the
//                start was accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fme_ip_ctrl;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    frac_x;
    logic [1:0]    frac_y;
    logic [AW-1:0] base_addr;
    logic          out_ready;

    logic          busy, done, rd_en, pipe_en, hor_en, hor_bypass;
    logic          win_shift, ver_bypass, out_valid, out_last;
    logic [AW-1:0] rd_addr;
    logic [1:0]    hor_type, ver_type;
    logic [2:0]    out_row;

    logic          b_busy, b_done, b_rd_en, b_pipe_en, b_hor_en, b_hor_bypass;
    logic          b_win_shift, b_ver_bypass, b_out_valid, b_out_last;
    logic [AW-1:0] b_rd_addr;
    logic [1:0]    b_hor_type, b_ver_type;
    logic [2:0]    b_out_row;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fme_ip_ctrl #(.ADDR_W(AW), .ROW_STRIDE(1)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .frac_x_i(frac_x),
        .frac_y_i(frac_y), .base_addr_i(base_addr), .out_ready_i(out_ready),
        .busy_o(busy), .done_o(done), .ref_rd_en_o(rd_en),
        .ref_rd_addr_o(rd_addr), .pipe_en_o(pipe_en), .hor_en_o(hor_en),
        .hor_type_o(hor_type), .hor_bypass_o(hor_bypass),
        .win_shift_o(win_shift), .ver_type_o(ver_type),
        .ver_bypass_o(ver_bypass), .out_valid_o(out_valid),
        .out_row_o(out_row), .out_last_o(out_last)
    );

    fme_ip_ctrl #(.ADDR_W(AW), .ROW_STRIDE(16)) u_dut_s16 (
        .clk(clk), .rst(rst), .start_i(start), .frac_x_i(frac_x),
        .frac_y_i(frac_y), .base_addr_i(base_addr), .out_ready_i(out_ready),
        .busy_o(b_busy), .done_o(b_done), .ref_rd_en_o(b_rd_en),
        .ref_rd_addr_o(b_rd_addr), .pipe_en_o(b_pipe_en), .hor_en_o(b_hor_en),
        .hor_type_o(b_hor_type), .hor_bypass_o(b_hor_bypass),
        .win_shift_o(b_win_shift), .ver_type_o(b_ver_type),
        .ver_bypass_o(b_ver_bypass), .out_valid_o(b_out_valid),
        .out_row_o(b_out_row), .out_last_o(b_out_last)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int ftype(input int f);
        return (f == 1) ? 1 : (f == 3) ? 2 : 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},      int'(busy), 0);
        chk({tag, ".done"},      int'(done), 0);
        chk({tag, ".rd_en"},     int'(rd_en), 0);
        chk({tag, ".rd_addr"},   int'(rd_addr), 0);
        chk({tag, ".pipe_en"},   int'(pipe_en), 1);
        chk({tag, ".hor_en"},    int'(hor_en), 0);
        chk({tag, ".win_shift"}, int'(win_shift), 0);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".out_last"},  int'(out_last), 0);
        chk({tag, ".hor_type"},  int'(hor_type), 0);
        chk({tag, ".ver_type"},  int'(ver_type), 0);
        chk({tag, ".hor_byp"},   int'(hor_bypass), 0);
        chk({tag, ".ver_byp"},   int'(ver_bypass), 0);
        chk({tag, ".b_done"},    int'(b_done), 0);
    endtask

    // ready_mode: 0 always ready, 1 not ready on cycles 12..14, 2 random.
    // restart_at / rst_at: cycle for a spurious start / mid-pass reset (0 = none).
    task automatic run_pass(input int fx0, input int fy0, input int b0,
                            input int ready_mode, input int restart_at,
                            input int rst_at);
        int  n, fr, first_out, last_out, done_k, k, c, exp_row;
        bit  stall, exp_rd, exp_hor, exp_ws, exp_ov, rdy;
        n         = (fy0 != 0) ? 15 : 8;
        fr        = (fy0 != 0) ? 0 : 3;
        first_out = (fy0 != 0) ? 10 : 3;
        last_out  = first_out + 7;
        done_k    = last_out + 2;

        // cycle 0: start accepted
        @(negedge clk);
        start     = 1'b1;
        frac_x    = 2'(fx0);
        frac_y    = 2'(fy0);
        base_addr = AW'(b0);
        out_ready = 1'b1;
        #1;
        chk("idle.busy", int'(busy), 0);
        @(posedge clk);

        k = 1;
        c = 1;
        while (k <= done_k + 1 && c < 200) begin
            @(negedge clk);
            start     = (c == restart_at);
            frac_x    = 2'($urandom_range(0, 3));
            frac_y    = 2'($urandom_range(0, 3));
            base_addr = AW'($urandom_range(0, 127));
            case (ready_mode)
                1:       rdy = !(c >= 12 && c <= 14);
                2:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;

            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                chk_all_zero("midrst");
                @(posedge clk);
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                #1;
                chk("postrst.done", int'(done), 0);
                chk("postrst.busy", int'(busy), 0);
                @(posedge clk);
                return;
            end

            exp_ov  = (k >= first_out) && (k <= last_out);
            exp_row = k - first_out;
            stall   = exp_ov && !rdy;
            exp_rd  = (k >= 1) && (k <= n) && !stall;
            exp_hor = (k >= 2) && (k <= n + 1);
            exp_ws  = (k >= 3) && (k <= n + 2);
            #1;
            chk("rd_en", int'(rd_en), int'(exp_rd));
            chk("rd_en_s16", int'(b_rd_en), int'(exp_rd));
            if (exp_rd) begin
                chk("rd_addr",     int'(rd_addr),   (b0 + (fr + k - 1)) % 128);
                chk("rd_addr_s16", int'(b_rd_addr), (b0 + (fr + k - 1) * 16) % 128);
            end
            chk("hor_en",    int'(hor_en),    int'(exp_hor));
            chk("win_shift", int'(win_shift), int'(exp_ws));
            chk("out_valid", int'(out_valid), int'(exp_ov));
            if (exp_ov) chk("out_row", int'(out_row), exp_row);
            chk("out_last", int'(out_last), int'(exp_ov && exp_row == 7));
            chk("pipe_en",  int'(pipe_en),  int'(!stall));
            chk("busy",     int'(busy),     int'(k <= last_out));
            chk("done",     int'(done),     int'(k == done_k));
            if (k <= done_k) begin
                chk("hor_type", int'(hor_type),   ftype(fx0));
                chk("ver_type", int'(ver_type),   ftype(fy0));
                chk("hor_byp",  int'(hor_bypass), int'(fx0 == 0));
                chk("ver_byp",  int'(ver_bypass), int'(fy0 == 0));
            end
            @(posedge clk);
            if (!stall) k++;
            c++;
        end
        if (c >= 200) chk("timeout", 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        frac_x    = 2'd0;
        frac_y    = 2'd0;
        base_addr = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        run_pass(2, 1, 10, 0, 0, 0);    // half / quarter, addresses 10..24
        run_pass(3, 0, 0, 0, 0, 0);     // vertical bypass, addresses 3..10
        run_pass(1, 2, 50, 1, 0, 0);    // output stall on cycles 12..14
        run_pass(2, 3, 20, 0, 5, 0);    // spurious start mid-pass
        run_pass(0, 1, 120, 0, 0, 0);   // address wrap (both strides)
        run_pass(1, 1, 30, 0, 0, 7);    // reset mid-pass
        run_pass(3, 2, 77, 0, 0, 0);    // full pass right after the reset
        for (int i = 0; i < 16; i++) begin
            run_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 127)), 2,
                     int'($urandom_range(0, 12)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
